// File: rtl/rom_load_pkg.sv
// rom_load_pkg
// Shared constants and types for the ROM download sequencer:
//   REGION_BASE / ROM_TOTAL - flat download map of the SNK triple-Z80 ROM set
//   rl_state_e              - sequencer FSM states
//   rom_entry_t             - one buffered byte {sel, ofs, data}
package rom_load_pkg;

   localparam int RL_NUM_REGIONS = 8;
   localparam int RL_OFS_W       = 20;

   // 0: main Z80, 1: sub Z80, 2: sound Z80, 3: text gfx,
   // 4: sprites, 5: tiles, 6: ADPCM samples, 7: PROMs / misc
   localparam logic [24:0] REGION_BASE [RL_NUM_REGIONS] = '{
      25'h000000, 25'h010000, 25'h020000, 25'h030000,
      25'h040000, 25'h080000, 25'h0C0000, 25'h100000
   };

   localparam logic [24:0] ROM_TOTAL = 25'h140000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } rl_state_e;

   typedef struct packed {
      logic [2:0]          sel;
      logic [RL_OFS_W-1:0] ofs;
      logic [7:0]          data;
   } rom_entry_t;

   localparam int ENTRY_W = $bits(rom_entry_t);

endpackage

// File: rtl/rom_load_fifo.sv
// rom_load_fifo
// Two-deep register FIFO; slot0 is always the head so the read side is a
// plain register with no mux.
//   i_clk, RESETn  clock, async active-low reset (clears contents)
//   push, din      write; ignored while full
//   pop            read; ignored while empty
//   head           oldest entry
//   count          occupancy 0..2
//   full, empty    occupancy flags
module rom_load_fifo #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         RESETn,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] slot0;
   logic [W-1:0] slot1;
   logic         push_ok;
   logic         pop_ok;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = slot0;

   always_ff @(posedge i_clk or negedge RESETn) begin
      if (!RESETn) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (count == 2'd0) slot0 <= din;
               else               slot1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - 2'd1;
            end
            // push_ok implies not full, so count is 1 here: the new byte
            // replaces the departing head directly.
            2'b11: slot0 <= din;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
// Routes hps_io ROM downloads (index 0) into the core's ROM regions through a
// 2-entry FIFO, throttles hps_io, holds the CPUs while loading and latches the
// game-select byte (index 1, address 0).
// Optional feature macro: ROM_CHECKSUM_EN adds per-region byte sums
// (chk_sel in, chk_sum out, 1-cycle read latency).
// Ports:
//   i_clk, RESETn                      clock, async active-low reset
//   ioctl_download/index/wr/addr/dout  hps_io download side
//   ioctl_wait                         back-pressure to hps_io
//   rom_we/sel/ofs/data, rom_ack       ROM write port, pops on we && ack
//   cpu_hold                           keep Z80s and video in reset
//   load_done                          one-cycle pulse after full drain
//   game                               latched game select
//   err_oob, err_ovf                   sticky errors, cleared on LOAD entry
//
// state    | meaning
// IDLE     | no load, CPUs running
// LOAD     | index-0 download active, CPUs held
// DRAIN    | download ended, flushing FIFO to ROM
// DONE     | FIFO empty, load_done pulse
module rom_load_sequencer
   import rom_load_pkg::*;
#(
   parameter int NUM_REGIONS = RL_NUM_REGIONS,
   parameter int OFS_W       = RL_OFS_W
) (
   input  logic             i_clk,
   input  logic             RESETn,
   input  logic             ioctl_download,
   input  logic [7:0]       ioctl_index,
   input  logic             ioctl_wr,
   input  logic [24:0]      ioctl_addr,
   input  logic [7:0]       ioctl_dout,
   output logic             ioctl_wait,
   output logic             rom_we,
   output logic [2:0]       rom_sel,
   output logic [OFS_W-1:0] rom_ofs,
   output logic [7:0]       rom_data,
   input  logic             rom_ack,
   output logic             cpu_hold,
   output logic             load_done,
   output logic [7:0]       game,
   output logic             err_oob,
   output logic             err_ovf
`ifdef ROM_CHECKSUM_EN
   ,
   input  logic [2:0]       chk_sel,
   output logic [15:0]      chk_sum
`endif
);

   rl_state_e          state;
   rl_state_e          state_nxt;
   logic               load_entry;
   logic               rom_dl;
   logic               strobe_rom;
   logic               in_range;
   logic               push_req;
   logic               push_ok;
   logic               rom_pop;
   logic               oob_hit;
   logic               ovf_hit;
   logic               game_hit;
   logic [2:0]         dec_sel;
   logic [24:0]        dec_base;
   rom_entry_t         push_entry;
   rom_entry_t         head_entry;
   logic [ENTRY_W-1:0] head_bits;
   logic [1:0]         fifo_count;
   logic [1:0]         fifo_count_nxt;
   logic               fifo_full;
   logic               fifo_empty;

   assign rom_dl     = ioctl_download && (ioctl_index == 8'd0);
   assign strobe_rom = ioctl_wr && (ioctl_index == 8'd0);
   assign in_range   = (ioctl_addr < ROM_TOTAL);
   assign push_req   = strobe_rom && in_range;
   assign oob_hit    = strobe_rom && !in_range;
   assign ovf_hit    = push_req && fifo_full;
   assign game_hit   = ioctl_wr && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0);
   assign push_ok    = push_req && !fifo_full;
   assign rom_pop    = rom_we && rom_ack;

   // Table is ascending, so the last base not above the address wins.
   always_comb begin
      dec_sel  = 3'd0;
      dec_base = REGION_BASE[0];
      for (int i = 1; i < NUM_REGIONS; i++) begin
         if (ioctl_addr >= REGION_BASE[i]) begin
            dec_sel  = 3'(i);
            dec_base = REGION_BASE[i];
         end
      end
   end

   always_comb begin
      push_entry.sel  = dec_sel;
      push_entry.ofs  = RL_OFS_W'(ioctl_addr - dec_base);
      push_entry.data = ioctl_dout;
   end

   rom_load_fifo #(.W(ENTRY_W)) u_fifo (
      .i_clk  (i_clk),
      .RESETn (RESETn),
      .push   (push_req),
      .din    (push_entry),
      .pop    (rom_pop),
      .head   (head_bits),
      .count  (fifo_count),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign head_entry     = head_bits;
   assign rom_we         = !fifo_empty;
   assign rom_sel        = head_entry.sel;
   assign rom_ofs        = head_entry.ofs;
   assign rom_data       = head_entry.data;
   assign fifo_count_nxt = fifo_count + 2'(push_ok) - 2'(rom_pop);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (rom_dl) state_nxt = ST_LOAD;
         ST_LOAD:  if (!ioctl_download) state_nxt = ST_DRAIN;
         // A restart resumes loading with whatever is still queued.
         ST_DRAIN: begin
            if (rom_dl)          state_nxt = ST_LOAD;
            else if (fifo_empty) state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign load_entry = (state_nxt == ST_LOAD) && (state != ST_LOAD);

   always_ff @(posedge i_clk or negedge RESETn) begin
      if (!RESETn) begin
         state      <= ST_IDLE;
         cpu_hold   <= 1'b0;
         load_done  <= 1'b0;
         ioctl_wait <= 1'b0;
         game       <= 8'd0;
         err_oob    <= 1'b0;
         err_ovf    <= 1'b0;
      end else begin
         state      <= state_nxt;
         cpu_hold   <= (state_nxt != ST_IDLE);
         load_done  <= (state_nxt == ST_DONE);
         // The FIFO's second slot absorbs the strobe hps_io can still
         // issue in the cycle wait rises.
         ioctl_wait <= (fifo_count_nxt != 2'd0);
         if (game_hit) game <= ioctl_dout;
         // An error on the entry strobe belongs to the new load, so set wins.
         if (oob_hit)         err_oob <= 1'b1;
         else if (load_entry) err_oob <= 1'b0;
         if (ovf_hit)         err_ovf <= 1'b1;
         else if (load_entry) err_ovf <= 1'b0;
      end
   end

`ifdef ROM_CHECKSUM_EN
   logic [15:0] chk_acc [RL_NUM_REGIONS];

   always_ff @(posedge i_clk or negedge RESETn) begin
      if (!RESETn) begin
         for (int i = 0; i < RL_NUM_REGIONS; i++) chk_acc[i] <= 16'd0;
         chk_sum <= 16'd0;
      end else begin
         if (load_entry) begin
            for (int i = 0; i < RL_NUM_REGIONS; i++) chk_acc[i] <= 16'd0;
         end else if (rom_pop) begin
            chk_acc[head_entry.sel] <= chk_acc[head_entry.sel] + 16'(head_entry.data);
         end
         chk_sum <= chk_acc[chk_sel];
      end
   end
`endif

endmodule

// File: tb/tb_rom_load_sequencer.sv
`timescale 1ns/1ps
module tb_rom_load_sequencer;

   logic        i_clk = 1'b0;
   logic        RESETn = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = 25'd0;
   logic [7:0]  ioctl_dout = 8'd0;
   logic        rom_ack = 1'b0;
   logic        ioctl_wait;
   logic        rom_we;
   logic [2:0]  rom_sel;
   logic [19:0] rom_ofs;
   logic [7:0]  rom_data;
   logic        cpu_hold;
   logic        load_done;
   logic [7:0]  game;
   logic        err_oob;
   logic        err_ovf;
`ifdef ROM_CHECKSUM_EN
   logic [2:0]  chk_sel = 3'd0;
   logic [15:0] chk_sum;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0]  sel;
      logic [19:0] ofs;
      logic [7:0]  data;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   exp_t held;

   localparam logic [24:0] TB_BASE [8] = '{
      25'h000000, 25'h010000, 25'h020000, 25'h030000,
      25'h040000, 25'h080000, 25'h0C0000, 25'h100000
   };
   localparam logic [24:0] TB_TOTAL = 25'h140000;

   always #9.328 i_clk = ~i_clk;

   rom_load_sequencer dut (
      .i_clk          (i_clk),
      .RESETn         (RESETn),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .rom_we         (rom_we),
      .rom_sel        (rom_sel),
      .rom_ofs        (rom_ofs),
      .rom_data       (rom_data),
      .rom_ack        (rom_ack),
      .cpu_hold       (cpu_hold),
      .load_done      (load_done),
      .game           (game),
      .err_oob        (err_oob),
      .err_ovf        (err_ovf)
`ifdef ROM_CHECKSUM_EN
      ,
      .chk_sel        (chk_sel),
      .chk_sum        (chk_sum)
`endif
   );

   // Search from the top region down; first base at or below the address.
   function automatic exp_t model(input logic [24:0] a, input logic [7:0] d);
      exp_t r;
      r.sel  = 3'd0;
      r.ofs  = a[19:0];
      r.data = d;
      for (int i = 7; i >= 0; i--) begin
         if (a >= TB_BASE[i]) begin
            r.sel = 3'(i);
            r.ofs = 20'(a - TB_BASE[i]);
            break;
         end
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_strobe(input logic [7:0] idx, input logic [24:0] a,
                               input logic [7:0] d, input bit exp_push);
      ioctl_wr    = 1'b1;
      ioctl_index = idx;
      ioctl_addr  = a;
      ioctl_dout  = d;
      if (exp_push) sb.push_back(model(a, d));
   endtask

   task automatic start_load();
      ioctl_download = 1'b1;
      ioctl_index    = 8'd0;
      ioctl_wr       = 1'b0;
      tick();
   endtask

   task automatic end_load();
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      rom_ack        = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      RESETn = 1'b0;
      repeat (2) tick();
      RESETn = 1'b1;
      tick();
      checks++;
      if ({ioctl_wait, rom_we, cpu_hold, load_done, err_oob, err_ovf} !== 6'b0)
         begin errors++; $display("FAIL reset_ctrl: got %b expected 000000",
            {ioctl_wait, rom_we, cpu_hold, load_done, err_oob, err_ovf}); end
      checks++;
      if ({rom_sel, rom_ofs, rom_data} !== 31'd0)
         begin errors++; $display("FAIL reset_rom_bus: got %h expected 0", {rom_sel, rom_ofs, rom_data}); end
      checks++;
      if (game !== 8'd0)
         begin errors++; $display("FAIL reset_game: got %h expected 00", game); end
   endtask

   task automatic test_back_to_back();
      logic [24:0] a;
      rom_ack = 1'b1;
      start_load();
      checks++;
      if (cpu_hold !== 1'b1)
         begin errors++; $display("FAIL b2b_cpu_hold: got %b expected 1", cpu_hold); end
      for (int i = 0; i < 16; i++) begin
         a = TB_BASE[1] - 25'd8 + 25'(i);
         drive_strobe(8'd0, a, 8'hA0 + 8'(i), 1'b1);
         tick();
         checks++;
         if (rom_we !== 1'b1)
            begin errors++; $display("FAIL b2b_latency[%0d]: rom_we got %b expected 1", i, rom_we); end
         if (rom_we === 1'b1 && rom_ack === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL b2b_unexpected: got %h expected none", {rom_sel, rom_ofs, rom_data});
            end else begin
               e = sb.pop_front();
               if ({rom_sel, rom_ofs, rom_data} !== e)
                  begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, {rom_sel, rom_ofs, rom_data}, e); end
            end
         end
         if (a == TB_BASE[1]) begin
            checks++;
            if (rom_sel !== 3'd1 || rom_ofs !== 20'd0)
               begin errors++; $display("FAIL b2b_boundary: got sel %0d ofs %h expected sel 1 ofs 0", rom_sel, rom_ofs); end
         end
         checks++;
         if (err_ovf !== 1'b0)
            begin errors++; $display("FAIL b2b_drop[%0d]: err_ovf got %b expected 0", i, err_ovf); end
      end
      ioctl_wr = 1'b0;
      tick();
      checks++;
      if (rom_we !== 1'b0 || sb.size() != 0)
         begin errors++; $display("FAIL b2b_drained: rom_we %b pending %0d expected 0 0", rom_we, sb.size()); end
      end_load();
   endtask

   task automatic test_stall();
      rom_ack = 1'b0;
      start_load();
      drive_strobe(8'd0, 25'h020010, 8'h11, 1'b1);
      tick();
      checks++;
      if (ioctl_wait !== 1'b1 || rom_we !== 1'b1)
         begin errors++; $display("FAIL stall_wait: wait %b we %b expected 1 1", ioctl_wait, rom_we); end
      held = {rom_sel, rom_ofs, rom_data};
      drive_strobe(8'd0, 25'h020011, 8'h22, 1'b1);
      tick();
      checks++;
      if (err_ovf !== 1'b0)
         begin errors++; $display("FAIL stall_ovf_early: got %b expected 0", err_ovf); end
      checks++;
      if ({rom_sel, rom_ofs, rom_data} !== held)
         begin errors++; $display("FAIL stall_stable_b: got %h expected %h", {rom_sel, rom_ofs, rom_data}, held); end
      drive_strobe(8'd0, 25'h020012, 8'h33, 1'b0);
      tick();
      checks++;
      if (err_ovf !== 1'b1)
         begin errors++; $display("FAIL stall_ovf: got %b expected 1", err_ovf); end
      ioctl_wr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         checks++;
         if ({rom_sel, rom_ofs, rom_data} !== held)
            begin errors++; $display("FAIL stall_stable[%0d]: got %h expected %h", k, {rom_sel, rom_ofs, rom_data}, held); end
      end
      rom_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (rom_we === 1'b1 && rom_ack === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL stall_unexpected: got %h expected none", {rom_sel, rom_ofs, rom_data});
            end else begin
               e = sb.pop_front();
               if ({rom_sel, rom_ofs, rom_data} !== e)
                  begin errors++; $display("FAIL stall_order[%0d]: got %h expected %h", k, {rom_sel, rom_ofs, rom_data}, e); end
            end
         end
         tick();
      end
      checks++;
      if (sb.size() != 0 || ioctl_wait !== 1'b0)
         begin errors++; $display("FAIL stall_end: pending %0d wait %b expected 0 0", sb.size(), ioctl_wait); end
      end_load();
   endtask

   task automatic test_oob();
      rom_ack = 1'b1;
      start_load();
      checks++;
      if (err_ovf !== 1'b0)
         begin errors++; $display("FAIL oob_ovf_clear: got %b expected 0", err_ovf); end
      drive_strobe(8'd0, TB_TOTAL, 8'h5A, 1'b0);
      tick();
      checks++;
      if (rom_we !== 1'b0 || err_oob !== 1'b1)
         begin errors++; $display("FAIL oob_drop: we %b err_oob %b expected 0 1", rom_we, err_oob); end
      drive_strobe(8'd0, TB_TOTAL - 25'd1, 8'hC3, 1'b1);
      tick();
      checks++;
      if (rom_sel !== 3'd7 || rom_ofs !== 20'h3FFFF)
         begin errors++; $display("FAIL oob_last: got sel %0d ofs %h expected sel 7 ofs 3ffff", rom_sel, rom_ofs); end
      if (rom_we === 1'b1 && rom_ack === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL oob_unexpected: got %h expected none", {rom_sel, rom_ofs, rom_data});
         end else begin
            e = sb.pop_front();
            if ({rom_sel, rom_ofs, rom_data} !== e)
               begin errors++; $display("FAIL oob_last_data: got %h expected %h", {rom_sel, rom_ofs, rom_data}, e); end
         end
      end
      ioctl_wr = 1'b0;
      end_load();
      checks++;
      if (err_oob !== 1'b1)
         begin errors++; $display("FAIL oob_sticky: got %b expected 1", err_oob); end
      start_load();
      checks++;
      if (err_oob !== 1'b0)
         begin errors++; $display("FAIL oob_clear: got %b expected 0", err_oob); end
      end_load();
   endtask

   task automatic test_game();
      ioctl_download = 1'b1;
      drive_strobe(8'd1, 25'd0, 8'h02, 1'b0);
      tick();
      checks++;
      if (game !== 8'h02 || rom_we !== 1'b0 || cpu_hold !== 1'b0)
         begin errors++; $display("FAIL game_latch: game %h we %b hold %b expected 02 0 0", game, rom_we, cpu_hold); end
      drive_strobe(8'd1, 25'd1, 8'h55, 1'b0);
      tick();
      checks++;
      if (game !== 8'h02)
         begin errors++; $display("FAIL game_addr1: got %h expected 02", game); end
      drive_strobe(8'd254, 25'd0, 8'h77, 1'b0);
      tick();
      checks++;
      if (game !== 8'h02 || rom_we !== 1'b0 || cpu_hold !== 1'b0)
         begin errors++; $display("FAIL game_dip: game %h we %b hold %b expected 02 0 0", game, rom_we, cpu_hold); end
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      tick();
   endtask

   task automatic test_drain();
      int  pulses;
      bit  prev_done;
      rom_ack = 1'b0;
      start_load();
      drive_strobe(8'd0, 25'h030004, 8'h3C, 1'b1);
      tick();
      drive_strobe(8'd0, 25'h030005, 8'hF5, 1'b1);
      tick();
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      tick();
      checks++;
      if (rom_we !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0)
         begin errors++; $display("FAIL drain_hold: we %b hold %b done %b expected 1 1 0", rom_we, cpu_hold, load_done); end
      rom_ack   = 1'b1;
      pulses    = 0;
      prev_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (rom_we === 1'b1 && rom_ack === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL drain_unexpected: got %h expected none", {rom_sel, rom_ofs, rom_data});
            end else begin
               e = sb.pop_front();
               if ({rom_sel, rom_ofs, rom_data} !== e)
                  begin errors++; $display("FAIL drain_data: got %h expected %h", {rom_sel, rom_ofs, rom_data}, e); end
            end
         end
         tick();
         if (prev_done) begin
            checks++;
            if (cpu_hold !== 1'b0)
               begin errors++; $display("FAIL drain_release: cpu_hold got %b expected 0", cpu_hold); end
         end
         if (load_done === 1'b1) begin
            pulses++;
            checks++;
            if (cpu_hold !== 1'b1)
               begin errors++; $display("FAIL drain_hold_at_done: got %b expected 1", cpu_hold); end
         end
         prev_done = (load_done === 1'b1);
      end
      checks++;
      if (pulses != 1)
         begin errors++; $display("FAIL drain_done_pulses: got %0d expected 1", pulses); end
`ifdef ROM_CHECKSUM_EN
      chk_sel = 3'd3;
      repeat (2) tick();
      checks++;
      if (chk_sum !== 16'h0131)
         begin errors++; $display("FAIL chk_region3: got %h expected 0131", chk_sum); end
      chk_sel = 3'd0;
      repeat (2) tick();
      checks++;
      if (chk_sum !== 16'h0000)
         begin errors++; $display("FAIL chk_region0: got %h expected 0000", chk_sum); end
`endif
   endtask

   task automatic test_reset_midload();
      rom_ack = 1'b0;
      start_load();
      drive_strobe(8'd0, 25'h040000, 8'h81, 1'b1);
      tick();
      drive_strobe(8'd0, 25'h040001, 8'h82, 1'b1);
      tick();
      ioctl_wr = 1'b0;
      checks++;
      if (ioctl_wait !== 1'b1 || rom_we !== 1'b1 || cpu_hold !== 1'b1)
         begin errors++; $display("FAIL rst_pre: wait %b we %b hold %b expected 1 1 1", ioctl_wait, rom_we, cpu_hold); end
      RESETn         = 1'b0;
      ioctl_download = 1'b0;
      sb.delete();
      #1;
      checks++;
      if ({ioctl_wait, rom_we, cpu_hold, load_done, err_oob, err_ovf} !== 6'b0 ||
          {rom_sel, rom_ofs, rom_data} !== 31'd0 || game !== 8'd0)
         begin errors++; $display("FAIL rst_async: ctrl %b bus %h game %h expected 0",
            {ioctl_wait, rom_we, cpu_hold, load_done, err_oob, err_ovf}, {rom_sel, rom_ofs, rom_data}, game); end
      tick();
      RESETn = 1'b1;
      tick();
      checks++;
      if (rom_we !== 1'b0 || cpu_hold !== 1'b0 || ioctl_wait !== 1'b0)
         begin errors++; $display("FAIL rst_idle: we %b hold %b wait %b expected 0 0 0", rom_we, cpu_hold, ioctl_wait); end
      rom_ack = 1'b1;
      start_load();
      drive_strobe(8'd0, 25'h000005, 8'h9E, 1'b1);
      tick();
      ioctl_wr = 1'b0;
      if (rom_we === 1'b1 && rom_ack === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL rst_unexpected: got %h expected none", {rom_sel, rom_ofs, rom_data});
         end else begin
            e = sb.pop_front();
            if ({rom_sel, rom_ofs, rom_data} !== e)
               begin errors++; $display("FAIL rst_fresh: got %h expected %h", {rom_sel, rom_ofs, rom_data}, e); end
         end
      end
      tick();
      checks++;
      if (rom_we !== 1'b0 || sb.size() != 0)
         begin errors++; $display("FAIL rst_empty: we %b pending %0d expected 0 0", rom_we, sb.size()); end
      end_load();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_oob();
      test_game();
      test_drain();
      test_reset_midload();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200us;
      $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog timeout");
   end

endmodule
